// File: rtl/axi4_video_pattern_gen_ext_if.sv
// AXI4-Stream video beat bundle shared by the pattern source and its sink.
//   tdata  : pixel {pad, c2, c1, c0}
//   tvalid : beat valid (master -> slave)
//   tready : sink ready (slave -> master)
//   tlast  : last pixel of an active line
//   tuser  : start of frame
`timescale 1ns/1ps
interface axi4_video_pattern_gen_ext_if #(
  parameter int TDATA_WIDTH = 32
);
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tvalid;
  logic                   tready;
  logic                   tlast;
  logic                   tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axi4_video_pattern_gen_ext.sv
// AXI4-Stream video test-pattern source. Walks a raster with active and
// blanking regions, one position per clock while the output slot is free,
// and emits one pixel per active position.
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   enable_i       : run request, sampled only at frame boundaries
//   pattern_i      : 0 bars, 1 ramp, 2 checker, 3 solid (latched at frame start)
//   solid_i        : solid colour {c2,c1,c0} (latched at frame start)
//   axis           : AXI4-Stream master (tdata/tvalid/tready/tlast/tuser)
//   frame_cnt_o    : completed frames, wraps at 2**16
//   busy_o         : high while in RUN
//
// state | meaning
// IDLE  | stream stopped, tvalid low, waiting for enable_i
// RUN   | raster running, frame end decides RUN or IDLE
`timescale 1ns/1ps
module axi4_video_pattern_gen_ext #(
  parameter int X_ACTIVE    = 1920,
  parameter int X_BLANKING  = 280,
  parameter int Y_ACTIVE    = 1080,
  parameter int Y_BLANKING  = 45,
  parameter int COMP_WIDTH  = 10,
  parameter int CHECK_LOG2  = 5,
  parameter int TDATA_WIDTH = ((3*COMP_WIDTH+7)/8)*8
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    enable_i,
  input  logic [1:0]              pattern_i,
  input  logic [3*COMP_WIDTH-1:0] solid_i,
  axi4_video_pattern_gen_ext_if.master axis,
  output logic [15:0]             frame_cnt_o,
  output logic                    busy_o
);

  localparam int X_RES = X_ACTIVE + X_BLANKING;
  localparam int Y_RES = Y_ACTIVE + Y_BLANKING;
  localparam int PXW   = (X_RES > 1) ? $clog2(X_RES) : 1;
  localparam int LNW   = (Y_RES > 1) ? $clog2(Y_RES) : 1;
  localparam int BAR_W = X_ACTIVE / 8;
  localparam int PIXW  = 3 * COMP_WIDTH;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_q, state_d;
  logic [PXW-1:0]          px_q, px_d;
  logic [LNW-1:0]          ln_q, ln_d;
  logic [1:0]              pat_q, pat_d;
  logic [PIXW-1:0]         solid_q, solid_d;
  logic [COMP_WIDTH-1:0]   phase_q, phase_d;
  logic [15:0]             frame_cnt_q, frame_cnt_d;
  logic                    tvalid_q, tvalid_d;
  logic                    tlast_q, tlast_d;
  logic                    tuser_q, tuser_d;
  logic [TDATA_WIDTH-1:0]  tdata_q, tdata_d;

  logic                    slot_free;
  logic                    active;
  logic [2:0]              bar_k;
  logic                    chk;
  logic [COMP_WIDTH-1:0]   ramp_c;
  logic [COMP_WIDTH-1:0]   ones;
  logic [PIXW-1:0]         pix;

  assign slot_free = !tvalid_q || axis.tready;
  assign ones      = {COMP_WIDTH{1'b1}};

  // Pixel value for the current raster position under the latched pattern.
  always_comb begin
    // Remainder pixels past 8*BAR_W stay in bar 7.
    if ((32'(px_q) / 32'(BAR_W)) > 32'd7) bar_k = 3'd7;
    else                                   bar_k = 3'(32'(px_q) / 32'(BAR_W));
    chk    = 1'((32'(px_q) >> CHECK_LOG2) & 32'd1) ^ 1'((32'(ln_q) >> CHECK_LOG2) & 32'd1);
    ramp_c = COMP_WIDTH'(px_q) + phase_q;
    case (pat_q)
      2'd0:    pix = {bar_k[2] ? ones : '0, bar_k[1] ? ones : '0, bar_k[0] ? ones : '0};
      2'd1:    pix = {3{ramp_c}};
      2'd2:    pix = {3{chk ? ones : {COMP_WIDTH{1'b0}}}};
      default: pix = solid_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    px_d        = px_q;
    ln_d        = ln_q;
    pat_d       = pat_q;
    solid_d     = solid_q;
    phase_d     = phase_q;
    frame_cnt_d = frame_cnt_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    tuser_d     = tuser_q;
    tdata_d     = tdata_q;
    active      = (32'(px_q) < 32'(X_ACTIVE)) && (32'(ln_q) < 32'(Y_ACTIVE));

    case (state_q)
      IDLE: begin
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        tuser_d  = 1'b0;
        if (enable_i) begin
          state_d = RUN;
          pat_d   = pattern_i;
          solid_d = solid_i;
          px_d    = '0;
          ln_d    = '0;
        end
      end
      RUN: begin
        if (slot_free) begin
          tvalid_d = active;
          if (active) begin
            tdata_d = TDATA_WIDTH'(pix);
            tlast_d = (32'(px_q) == 32'(X_ACTIVE - 1));
            tuser_d = (px_q == '0) && (ln_q == '0);
          end else begin
            tlast_d = 1'b0;
            tuser_d = 1'b0;
          end
          if (32'(px_q) == 32'(X_RES - 1)) begin
            px_d = '0;
            if (32'(ln_q) == 32'(Y_RES - 1)) begin
              // Frame end: the only point where run state and pattern change.
              ln_d        = '0;
              frame_cnt_d = frame_cnt_q + 16'd1;
              phase_d     = phase_q + 1'b1;
              if (!enable_i) begin
                state_d = IDLE;
              end else begin
                pat_d   = pattern_i;
                solid_d = solid_i;
              end
            end else begin
              ln_d = ln_q + 1'b1;
            end
          end else begin
            px_d = px_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      px_q        <= '0;
      ln_q        <= '0;
      pat_q       <= '0;
      solid_q     <= '0;
      phase_q     <= '0;
      frame_cnt_q <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
      tdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      px_q        <= px_d;
      ln_q        <= ln_d;
      pat_q       <= pat_d;
      solid_q     <= solid_d;
      phase_q     <= phase_d;
      frame_cnt_q <= frame_cnt_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
      tdata_q     <= tdata_d;
    end
  end

  assign axis.tdata  = tdata_q;
  assign axis.tvalid = tvalid_q;
  assign axis.tlast  = tlast_q;
  assign axis.tuser  = tuser_q;
  assign frame_cnt_o = frame_cnt_q;
  assign busy_o      = (state_q == RUN);

endmodule

// File: doc/axi4_video_pattern_gen_ext.md
Name: axi4_video_pattern_gen_ext

Overview:
Parametrised AXI4-Stream video test-pattern source for the pipeline's video input. Generates one pixel per beat of a raster with programmable active and blanking sizes, component width and run-time pattern selection (colour bars, scrolling ramp, checkerboard, solid colour). Honours downstream tready backpressure and frame-aligned start/stop. Feeds downstream video blocks in place of a sensor during bring-up and regression.

Parameters:
X_ACTIVE, 1920, active pixels per line (>= 8)
X_BLANKING, 280, blanking clocks per line (>= 1)
Y_ACTIVE, 1080, active lines per frame (>= 1)
Y_BLANKING, 45, blanking lines per frame (>= 0)
COMP_WIDTH, 10, bits per colour component (1..16)
CHECK_LOG2, 5, checkerboard square edge = 2**CHECK_LOG2 pixels
TDATA_WIDTH, ((3*COMP_WIDTH+7)/8)*8, derived tdata width; upper pad bits are 0

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous reset, active low
enable_i  in  1  run request, evaluated at frame boundaries
pattern_i  in  2  0 bars, 1 ramp, 2 checker, 3 solid; latched at frame start
solid_i  in  3*COMP_WIDTH  solid colour {c2,c1,c0}; latched at frame start
tdata_o  out  TDATA_WIDTH  pixel: c0 [COMP_WIDTH-1:0], c1 next, c2 next, pad 0
tvalid_o  out  1  beat valid
tready_i  in  1  downstream ready
tlast_o  out  1  last pixel of an active line
tuser_o  out  1  start of frame (pixel 0, line 0)
frame_cnt_o  out  16  completed frames, wraps at 2**16
busy_o  out  1  FSM in RUN

Behaviour:
- Reset (async assert, any time): tvalid_o, tlast_o, tuser_o, tdata_o, frame_cnt_o, busy_o = 0; px/ln counters = 0; ramp phase = 0; FSM -> IDLE. In-flight beat is dropped.
- Counters: px_cnt 0..X_ACTIVE+X_BLANKING-1, ln_cnt 0..Y_ACTIVE+Y_BLANKING-1; ln_cnt advances when px_cnt wraps. Both are sized by $clog2 of their full range.
- Slot free = !tvalid_o || tready_i. When not free, every register holds: counters, data, tlast, tuser. tdata_o is stable while tvalid_o && !tready_i.
- FSM IDLE: tvalid_o = 0. If enable_i = 1, go to RUN next cycle, latch pattern_i/solid_i and set counters to (0,0).
- FSM RUN, slot free, each clock: if (px < X_ACTIVE && ln < Y_ACTIVE), load tvalid_o = 1 and data/tlast/tuser for (px,ln); otherwise load tvalid_o = 0. Then advance the position. Blanking positions cost one clock each.
- Latency: first beat (tuser = 1) is valid 1 clock after entering RUN. With tready_i held at 1, the output cadence equals the free-running raster, one position per clock.
- tlast_o = 1 when px = X_ACTIVE-1. tuser_o = 1 when px = 0 and ln = 0. Both apply only to valid beats.
- Frame end is the step off (X_RES-1, Y_RES-1). On that step:
  - frame_cnt_o increments.
  - Ramp phase increments (mod 2**COMP_WIDTH).
  - If enable_i = 0, go to IDLE. Otherwise stay in RUN and re-latch pattern_i/solid_i.
- Pattern changes and enable changes never take effect mid-frame.
- Colour bars: bar k = min(px / (X_ACTIVE/8), 7), so the remainder pixels extend bar 7. c0 = all ones if k[0], c1 = all ones if k[1], c2 = all ones if k[2], otherwise 0.
- Ramp: c0 = c1 = c2 = (px + phase) mod 2**COMP_WIDTH.
- Checker: all components all ones if px[CHECK_LOG2] ^ ln[CHECK_LOG2], otherwise 0.
- Solid: latched solid_i.
- Y_BLANKING = 0: the frame end immediately follows the last active line's horizontal blanking. No extra lines.

Test Plan:
1. X_ACTIVE=16, X_BLANKING=4, Y_ACTIVE=4, Y_BLANKING=2, COMP_WIDTH=10, pattern 0, tready=1, enable=1 -> 64 beats per frame. Bars are 2 px wide with tdata 0x0, 0x3FF, 0xFFC00, 0xFFFFF, 0x3FF00000, 0x3FF003FF, 0x3FFFFC00, 0x3FFFFFFF. tlast on every 16th beat, tuser only on the first. Frame period is 20*6 = 120 clocks. frame_cnt = 1 after frame 1.
2. Same config, tready random 50% -> exactly 64 beats per frame in raster order. tdata/tlast/tuser stable during every stall. No beat lost or duplicated.
3. Pattern 1 over 3 frames -> first beat of frame n has c0 = c1 = c2 = n. Pixel 15 of frame 0 = 15.
4. Change pattern_i from 3 to 2 mid-frame with solid_i = 0x155 per component -> the current frame stays all 0x155. Next frame is checker; with CHECK_LOG2=2, pixel (4,0) = all ones and (0,0) = 0.
5. Drop enable_i mid-frame -> the frame completes fully, then busy_o = 0, tvalid_o = 0. Raise enable_i -> next beat has tuser = 1 one clock after RUN entry.
6. Assert rst_n_i low during a stalled beat -> all outputs 0 immediately. After release with enable = 1, the stream restarts at (0,0) with tuser = 1 and frame_cnt = 0.
